// File: rtl/mem_write_arbiter.sv
// Four-requester round-robin write arbiter feeding a single-port MemoryUnit.
// Optional MEM_ARB_WRITE_COUNT_EN adds a saturating write_count output.
module mem_write_arbiter #(
  parameter int DATA_W = 35,
  parameter int N_REQ  = 4
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  output logic [1:0]              grant_id,
  output logic                    busy,
  output logic                    mem_wren,
  output logic [DATA_W-1:0]       mem_din
`ifdef MEM_ARB_WRITE_COUNT_EN
  ,
  output logic [15:0]             write_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    WRITE,
    RELEASE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        last_grant;
  logic [1:0]        win;
  logic [1:0]        idx;
  logic              found;
  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] words [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_word
    assign words[i] = req_data[i*DATA_W +: DATA_W];
  end

  // Search starts just past the previous winner, wrapping mod 4.
  always_comb begin
    win   = last_grant;
    idx   = last_grant;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = last_grant + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (found) state_nxt = LATCH;
      LATCH:   state_nxt = WRITE;
      WRITE:   state_nxt = RELEASE;
      RELEASE: if (!req[grant_id]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state      <= IDLE;
      grant_id   <= 2'd0;
      last_grant <= 2'd3;
      word_q     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && found) begin
        grant_id   <= win;
        last_grant <= win;
        word_q     <= words[win];
      end
    end
  end

  assign busy     = (state != IDLE);
  assign mem_wren = (state == WRITE);
  assign mem_din  = word_q;
  assign ack      = {N_REQ{mem_wren}} & (N_REQ'(1) << grant_id);

`ifdef MEM_ARB_WRITE_COUNT_EN
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      write_count <= 16'd0;
    end else if (state == WRITE && write_count != 16'hFFFF) begin
      write_count <= write_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Directed self-checking bench for mem_write_arbiter.
// Define MEM_ARB_WRITE_COUNT_EN to also exercise write_count.
module tb_mem_write_arbiter;

  localparam int DW = 35;
  localparam int NR = 4;

  logic             clk = 1'b0;
  logic             arst;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    ack;
  logic [1:0]       grant_id;
  logic             busy;
  logic             mem_wren;
  logic [DW-1:0]    mem_din;
`ifdef MEM_ARB_WRITE_COUNT_EN
  logic [15:0]      write_count;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [DW-1:0] W0 = 35'b01010101010101010101010101010101010;
  localparam logic [DW-1:0] W1 = 35'b01010101010101010101011111111111111;
  localparam logic [DW-1:0] D0 = 35'h1_0000_00A0;
  localparam logic [DW-1:0] D1 = 35'h2_0000_00B1;
  localparam logic [DW-1:0] D2 = 35'h3_0000_00C2;
  localparam logic [DW-1:0] D3 = 35'h4_0000_00D3;

  mem_write_arbiter #(.DATA_W(DW), .N_REQ(NR)) dut (
    .clk      (clk),
    .arst     (arst),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .grant_id (grant_id),
    .busy     (busy),
    .mem_wren (mem_wren),
    .mem_din  (mem_din)
`ifdef MEM_ARB_WRITE_COUNT_EN
    ,
    .write_count (write_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int wr;
    logic [DW-1:0] dw [NR];
    dw[0] = D0; dw[1] = D1; dw[2] = D2; dw[3] = D3;

    arst     = 1'b0;
    req      = '0;
    req_data = '0;
    #3;
    chk("rst_wren", 64'(mem_wren), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_gid", 64'(grant_id), 64'd0);
    chk("rst_din", 64'(mem_din), 64'd0);
    @(posedge clk);
    #1;
    arst = 1'b1;

    // Single request, latency, and data held across a LATCH-time change
    req_data[0 +: DW] = W0;
    req = 4'b0001;
    step();
    chk("lat_busy", 64'(busy), 64'd1);
    chk("lat_wren", 64'(mem_wren), 64'd0);
    chk("lat_din", 64'(mem_din), 64'(W0));
    req_data[0 +: DW] = W1;
    step();
    chk("wr_wren", 64'(mem_wren), 64'd1);
    chk("wr_ack", 64'(ack), 64'b0001);
    chk("wr_gid", 64'(grant_id), 64'd0);
    chk("wr_din", 64'(mem_din), 64'(W0));
    req = '0;
    step();
    chk("rel_busy", 64'(busy), 64'd1);
    chk("rel_ack", 64'(ack), 64'd0);
    step();
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_din", 64'(mem_din), 64'(W0));

    // Round robin over all four, fresh from reset
    #2 arst = 1'b0;
    #1 arst = 1'b1;
    req_data = {D3, D2, D1, D0};
    req = 4'b1111;
    for (int g = 0; g < NR; g++) begin
      n = 0;
      while (!mem_wren && n < 12) begin
        step();
        n++;
      end
      chk("rr_wren", 64'(mem_wren), 64'd1);
      chk("rr_gap", 64'(n), (g == 0) ? 64'd2 : 64'd3);
      chk("rr_ack", 64'(ack), 64'(4'b0001 << g));
      chk("rr_gid", 64'(grant_id), 64'(g));
      chk("rr_din", 64'(mem_din), 64'(dw[g]));
      req[g] = 1'b0;
      step();
      chk("rr_1cyc", 64'(mem_wren), 64'd0);
    end

    // Held request writes only once
    req = 4'b0100;
    wr = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mem_wren) wr++;
    end
    chk("hold_writes", 64'(wr), 64'd1);
    chk("hold_busy", 64'(busy), 64'd1);
    chk("hold_gid", 64'(grant_id), 64'd2);
    req = '0;
    step();
    chk("hold_free", 64'(busy), 64'd0);

    // Reset during LATCH aborts the write
    req_data[0 +: DW] = W0;
    req = 4'b0001;
    step();
    chk("ab_latch", 64'(busy), 64'd1);
    arst = 1'b0;
    #1;
    chk("ab_wren", 64'(mem_wren), 64'd0);
    chk("ab_ack", 64'(ack), 64'd0);
    chk("ab_busy", 64'(busy), 64'd0);
    chk("ab_gid", 64'(grant_id), 64'd0);
    chk("ab_din", 64'(mem_din), 64'd0);
    step();
    chk("ab_nowr", 64'(mem_wren), 64'd0);
    arst = 1'b1;
    n = 0;
    while (!mem_wren && n < 12) begin
      step();
      n++;
    end
    chk("ab_lat", 64'(n), 64'd2);
    chk("ab_rack", 64'(ack), 64'b0001);
    chk("ab_rdin", 64'(mem_din), 64'(W0));
    req = '0;
    step();
    step();
    chk("ab_idle", 64'(busy), 64'd0);

`ifdef MEM_ARB_WRITE_COUNT_EN
    #2 arst = 1'b0;
    #1;
    chk("wc_rst", 64'(write_count), 64'd0);
    arst = 1'b1;
    for (int w = 0; w < 5; w++) begin
      req = 4'b0001;
      n = 0;
      while (!mem_wren && n < 12) begin
        step();
        n++;
      end
      chk("wc_wren", 64'(mem_wren), 64'd1);
      req = '0;
      step();
      step();
    end
    chk("wc_five", 64'(write_count), 64'd5);
    arst = 1'b0;
    #1;
    chk("wc_clr", 64'(write_count), 64'd0);
    arst = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
